// File: rtl/gpio_irq_pkg.sv
// Shared register map offsets, interrupt encodings and the per-pin event helper
// for gpio_irq_ctrl_ip.
package gpio_irq_pkg;

   localparam logic [7:0] OFF_DATA      = 8'h00;
   localparam logic [7:0] OFF_DIR       = 8'h04;
   localparam logic [7:0] OFF_READ      = 8'h08;
   localparam logic [7:0] OFF_SET       = 8'h0C;
   localparam logic [7:0] OFF_CLR       = 8'h10;
   localparam logic [7:0] OFF_TGL       = 8'h14;
   localparam logic [7:0] OFF_IRQ_EN    = 8'h18;
   localparam logic [7:0] OFF_IRQ_TYPE  = 8'h1C;
   localparam logic [7:0] OFF_IRQ_POL   = 8'h20;
   localparam logic [7:0] OFF_IRQ_STAT  = 8'h24;
   localparam logic [7:0] OFF_DEB_LIMIT = 8'h28;

   typedef enum logic {IRQ_LEVEL = 1'b0, IRQ_EDGE = 1'b1} irq_type_e;
   typedef enum logic {POL_HIGH_RISE = 1'b0, POL_LOW_FALL = 1'b1} irq_pol_e;

   // Ungated event for one pin: edge compares filtered vs delayed, level compares against POL.
   function automatic logic irq_event(input logic pin_f, input logic pin_p,
                                      input logic typ, input logic pol);
      logic hit;
      if (irq_type_e'(typ) == IRQ_EDGE)
         hit = (irq_pol_e'(pol) == POL_LOW_FALL) ? (~pin_f & pin_p) : (pin_f & ~pin_p);
      else
         hit = (pin_f == ~pol);
      return hit;
   endfunction

endpackage

// File: rtl/gpio_irq_ctrl_ip_if.sv
// Simple valid/we memory bus shared by the GPIO peripherals.
interface gpio_irq_ctrl_ip_if;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   modport master (output bus_valid, bus_we, bus_addr, bus_wdata, input bus_rdata);
   modport slave  (input bus_valid, bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/gpio_in_filter.sv
// Pin input synchroniser with optional per-bit debounce, enabled by GPIO_IRQ_DEBOUNCE_EN.
module gpio_in_filter #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef GPIO_IRQ_DEBOUNCE_EN
   input  logic [DEB_CNT_W-1:0] deb_limit_i,
`endif
   input  logic [WIDTH-1:0]     pin_i,
   output logic [WIDTH-1:0]     pin_f_o
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  pin_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
   end

   assign pin_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_DEBOUNCE_EN
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_deb
         logic [DEB_CNT_W-1:0] cnt_q;
         logic                 f_q;

         // >= keeps a counter from wrapping if DEB_LIMIT is lowered mid-count.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= '0;
               f_q   <= 1'b0;
            end else if (pin_s[gi] == f_q) begin
               cnt_q <= '0;
            end else if (cnt_q >= deb_limit_i) begin
               cnt_q <= '0;
               f_q   <= pin_s[gi];
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign pin_f_o[gi] = f_q;
      end
   endgenerate
`else
   logic [DEB_CNT_W-1:0] unused_deb_w;
   assign unused_deb_w = '0;
   assign pin_f_o      = pin_s;
`endif

endmodule

// File: rtl/gpio_irq_ctrl_ip.sv
// GPIO controller with atomic set/clr/tgl and per-pin edge/level interrupts.
// Optional input debounce and DEB_LIMIT register with GPIO_IRQ_DEBOUNCE_EN.
module gpio_irq_ctrl_ip
   import gpio_irq_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   gpio_irq_ctrl_ip_if.slave  bus,
   input  logic [WIDTH-1:0]   gpio_in,
   output logic [WIDTH-1:0]   gpio_out,
   output logic [WIDTH-1:0]   gpio_oe,
   output logic               irq
);

   logic [WIDTH-1:0] data_q, data_d, dir_q, dir_d;
   logic [WIDTH-1:0] en_q, en_d, type_q, type_d, pol_q, pol_d;
   logic [WIDTH-1:0] stat_q, stat_d, pin_p_q, pin_f, evt, w1c;
   logic             irq_q;
   logic             wr_en;
   logic [7:0]       off;
   logic [WIDTH-1:0] wd;
   logic [31:0]      rd;
   logic             unused_bus;
`ifdef GPIO_IRQ_DEBOUNCE_EN
   logic [DEB_CNT_W-1:0] deb_limit_q, deb_limit_d;
`endif

   assign wr_en      = bus.bus_valid & bus.bus_we;
   assign off        = bus.bus_addr[7:0];
   assign wd         = bus.bus_wdata[WIDTH-1:0];
   assign unused_bus = ^{bus.bus_addr[31:8], bus.bus_wdata};

   gpio_in_filter #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CNT_W   (DEB_CNT_W)
   ) u_filter (
      .clk         (clk),
      .rst         (rst),
`ifdef GPIO_IRQ_DEBOUNCE_EN
      .deb_limit_i (deb_limit_q),
`endif
      .pin_i       (gpio_in),
      .pin_f_o     (pin_f)
   );

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_evt
         assign evt[gi] = en_q[gi] & ~dir_q[gi]
                        & irq_event(pin_f[gi], pin_p_q[gi], type_q[gi], pol_q[gi]);
      end
   endgenerate

   always_comb begin
      data_d = data_q;
      dir_d  = dir_q;
      en_d   = en_q;
      type_d = type_q;
      pol_d  = pol_q;
      w1c    = '0;
`ifdef GPIO_IRQ_DEBOUNCE_EN
      deb_limit_d = deb_limit_q;
`endif
      if (wr_en) begin
         case (off)
            OFF_DATA:      data_d = wd;
            OFF_DIR:       dir_d  = wd;
            OFF_SET:       data_d = data_q | wd;
            OFF_CLR:       data_d = data_q & ~wd;
            OFF_TGL:       data_d = data_q ^ wd;
            OFF_IRQ_EN:    en_d   = wd;
            OFF_IRQ_TYPE:  type_d = wd;
            OFF_IRQ_POL:   pol_d  = wd;
            OFF_IRQ_STAT:  w1c    = wd;
`ifdef GPIO_IRQ_DEBOUNCE_EN
            OFF_DEB_LIMIT: deb_limit_d = bus.bus_wdata[DEB_CNT_W-1:0];
`endif
            default: ;
         endcase
      end
      // Set has priority so an active level source survives a W1C.
      stat_d = (stat_q & ~w1c) | evt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         dir_q   <= '0;
         en_q    <= '0;
         type_q  <= '0;
         pol_q   <= '0;
         stat_q  <= '0;
         pin_p_q <= '0;
         irq_q   <= 1'b0;
`ifdef GPIO_IRQ_DEBOUNCE_EN
         deb_limit_q <= '0;
`endif
      end else begin
         data_q  <= data_d;
         dir_q   <= dir_d;
         en_q    <= en_d;
         type_q  <= type_d;
         pol_q   <= pol_d;
         stat_q  <= stat_d;
         pin_p_q <= pin_f;
         irq_q   <= |(stat_q & en_q);
`ifdef GPIO_IRQ_DEBOUNCE_EN
         deb_limit_q <= deb_limit_d;
`endif
      end
   end

   always_comb begin
      rd = '0;
      case (off)
         OFF_DATA:      rd[WIDTH-1:0] = data_q;
         OFF_DIR:       rd[WIDTH-1:0] = dir_q;
         OFF_READ:      rd[WIDTH-1:0] = (dir_q & data_q) | (~dir_q & pin_f);
         OFF_IRQ_EN:    rd[WIDTH-1:0] = en_q;
         OFF_IRQ_TYPE:  rd[WIDTH-1:0] = type_q;
         OFF_IRQ_POL:   rd[WIDTH-1:0] = pol_q;
         OFF_IRQ_STAT:  rd[WIDTH-1:0] = stat_q;
`ifdef GPIO_IRQ_DEBOUNCE_EN
         OFF_DEB_LIMIT: rd[DEB_CNT_W-1:0] = deb_limit_q;
`endif
         default: ;
      endcase
   end

   assign bus.bus_rdata = rd;
   assign gpio_out      = data_q & dir_q;
   assign gpio_oe       = dir_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl_ip.sv
// Self-checking bench for gpio_irq_ctrl_ip; debounce scenario runs when GPIO_IRQ_DEBOUNCE_EN is defined.
module tb_gpio_irq_ctrl_ip;
   import gpio_irq_pkg::*;

   localparam int SYNC = 2;
`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam int DEB_LAT = 1;
`else
   localparam int DEB_LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out, gpio_oe;
   logic        irq;

   int          n_run  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] rd, ex;

   gpio_irq_ctrl_ip_if bus_if();

   gpio_irq_ctrl_ip #(.WIDTH(32), .SYNC_STAGES(SYNC), .DEB_CNT_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish (actual=timeout required=finish)");
      $fatal(1, "watchdog");
   end

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.bus_valid = 1'b1;
      bus_if.bus_we    = 1'b1;
      bus_if.bus_addr  = {24'h0, a};
      bus_if.bus_wdata = d;
      @(posedge clk);
      #1;
      bus_if.bus_valid = 1'b0;
      bus_if.bus_we    = 1'b0;
      $display("[TB] wr addr=%02h data=%08h", a, d);
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_if.bus_valid = 1'b1;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = {24'h0, a};
      #1;
      d = bus_if.bus_rdata;
      bus_if.bus_valid = 1'b0;
      $display("[TB] rd addr=%02h data=%08h", a, d);
   endtask

   task automatic test_reset();
      logic [7:0] offs [12];
      for (int i = 0; i < 12; i++) offs[i] = 8'(i * 4);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq actual=%0b required=0", irq); end
      n_run++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_gpio_out actual=%08h required=0", gpio_out); end
      n_run++; if (gpio_oe !== 32'h0) begin n_fail++; $display("FAIL reset_gpio_oe actual=%08h required=0", gpio_oe); end
      for (int i = 0; i < 12; i++) exp_q.push_back(32'h0);
      for (int i = 0; i < 12; i++) begin
         bus_read(offs[i], rd);
         ex = exp_q.pop_front();
         n_run++;
         if (rd !== ex) begin n_fail++; $display("FAIL reset_read_%02h actual=%08h required=%08h", offs[i], rd, ex); end
      end
      bus_write(OFF_DIR, 32'hFF);
      bus_write(OFF_DATA, 32'hA5);
      exp_q.push_back(32'hA5);
      n_run++; ex = exp_q.pop_front();
      if (gpio_out !== ex) begin n_fail++; $display("FAIL gpio_out actual=%08h required=%08h", gpio_out, ex); end
      n_run++; if (gpio_oe !== 32'hFF) begin n_fail++; $display("FAIL gpio_oe actual=%08h required=000000ff", gpio_oe); end
      exp_q.push_back(32'hA5);
      bus_read(OFF_READ, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL read_a5 actual=%08h required=%08h", rd, ex); end
   endtask

   task automatic test_set_clr_tgl();
      logic [7:0] op_off [4];
      logic [31:0] op_val [4];
      op_off = '{OFF_DATA, OFF_SET, OFF_CLR, OFF_TGL};
      op_val = '{32'hF0, 32'h0F, 32'h81, 32'hFF};
      exp_q.push_back(32'hF0); exp_q.push_back(32'hFF);
      exp_q.push_back(32'h7E); exp_q.push_back(32'h81);
      for (int i = 0; i < 4; i++) begin
         bus_write(op_off[i], op_val[i]);
         bus_read(OFF_DATA, rd); ex = exp_q.pop_front(); n_run++;
         if (rd !== ex) begin n_fail++; $display("FAIL atomic_op%0d actual=%08h required=%08h", i, rd, ex); end
      end
      for (int i = 1; i < 4; i++) begin
         exp_q.push_back(32'h0);
         bus_read(op_off[i], rd); ex = exp_q.pop_front(); n_run++;
         if (rd !== ex) begin n_fail++; $display("FAIL wo_readback_%02h actual=%08h required=%08h", op_off[i], rd, ex); end
      end
      bus_write(OFF_READ, 32'h55);
      bus_write(8'h2C, 32'hFFFF_FFFF);
      exp_q.push_back(32'h81); exp_q.push_back(32'h0);
      bus_read(OFF_DATA, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL ro_write_ignored actual=%08h required=%08h", rd, ex); end
      bus_read(8'h2C, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL unmapped_read actual=%08h required=%08h", rd, ex); end
   endtask

   task automatic test_edge_irq();
      bus_write(OFF_DIR, 32'h0);
      bus_write(OFF_DATA, 32'h0);
      bus_write(OFF_IRQ_TYPE, 32'h8);
      bus_write(OFF_IRQ_POL, 32'h0);
      bus_write(OFF_IRQ_EN, 32'h8);
      exp_q.push_back(32'h0); exp_q.push_back(32'h8); exp_q.push_back(32'h8);
      @(negedge clk) gpio_in = 32'h8;
      @(posedge clk);
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL edge_stat_early actual=%08h required=%08h", rd, ex); end
      repeat (SYNC - 1 + DEB_LAT) @(posedge clk);
      bus_read(OFF_READ, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL edge_read_latency actual=%08h required=%08h", rd, ex); end
      @(posedge clk);
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL edge_stat_set actual=%08h required=%08h", rd, ex); end
      n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_early actual=%0b required=0", irq); end
      @(posedge clk); #1;
      n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq_set actual=%0b required=1", irq); end
      bus_write(OFF_IRQ_STAT, 32'h8);
      exp_q.push_back(32'h0);
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL edge_w1c actual=%08h required=%08h", rd, ex); end
      @(posedge clk); #1;
      n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_clear actual=%0b required=0", irq); end
      @(negedge clk) gpio_in = 32'h0;
      repeat (6) @(posedge clk);
      exp_q.push_back(32'h0);
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL edge_falling_ignored actual=%08h required=%08h", rd, ex); end
   endtask

   task automatic test_level_low();
      bus_write(OFF_IRQ_TYPE, 32'h0);
      bus_write(OFF_IRQ_POL, 32'h20);
      bus_write(OFF_IRQ_EN, 32'h20);
      @(posedge clk);
      exp_q.push_back(32'h20); exp_q.push_back(32'h20); exp_q.push_back(32'h0);
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL level_set actual=%08h required=%08h", rd, ex); end
      bus_write(OFF_IRQ_STAT, 32'h20);
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL level_sticky_active actual=%08h required=%08h", rd, ex); end
      @(negedge clk) gpio_in = 32'h20;
      repeat (6) @(posedge clk);
      bus_write(OFF_IRQ_STAT, 32'h20);
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL level_clear_released actual=%08h required=%08h", rd, ex); end
      @(posedge clk); #1;
      n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL level_irq_clear actual=%0b required=0", irq); end
   endtask

   task automatic test_set_wins();
      @(negedge clk) gpio_in = 32'h0;
      bus_write(OFF_IRQ_EN, 32'h0);
      bus_write(OFF_IRQ_TYPE, 32'h8);
      bus_write(OFF_IRQ_POL, 32'h0);
      repeat (6) @(posedge clk);
      bus_write(OFF_IRQ_STAT, 32'hFFFF_FFFF);
      bus_write(OFF_IRQ_EN, 32'h8);
      exp_q.push_back(32'h8);
      @(negedge clk) gpio_in = 32'h8;
      @(posedge clk);
      repeat (SYNC - 1 + DEB_LAT) @(posedge clk);
      bus_write(OFF_IRQ_STAT, 32'h8);
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL set_wins_over_w1c actual=%08h required=%08h", rd, ex); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] offs [4];
      offs = '{OFF_DATA, OFF_DIR, OFF_IRQ_EN, OFF_IRQ_STAT};
      bus_write(OFF_DIR, 32'hFF);
      bus_write(OFF_DATA, 32'h3C);
      n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq actual=%0b required=1", irq); end
      n_run++; if (gpio_out !== 32'h3C) begin n_fail++; $display("FAIL pre_reset_out actual=%08h required=0000003c", gpio_out); end
      @(negedge clk) rst = 1'b1;
      #1;
      n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL async_rst_irq actual=%0b required=0", irq); end
      n_run++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL async_rst_out actual=%08h required=0", gpio_out); end
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
      for (int i = 0; i < 4; i++) begin
         bus_read(offs[i], rd); ex = exp_q.pop_front(); n_run++;
         if (rd !== ex) begin n_fail++; $display("FAIL async_rst_reg_%02h actual=%08h required=%08h", offs[i], rd, ex); end
      end
      @(negedge clk) rst = 1'b0;
      repeat (5) @(posedge clk);
      exp_q.push_back(32'h0);
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL post_rst_stat actual=%08h required=%08h", rd, ex); end
      n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL post_rst_irq actual=%0b required=0", irq); end
      @(negedge clk) gpio_in = 32'h0;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_debounce();
`ifdef GPIO_IRQ_DEBOUNCE_EN
      bus_write(OFF_IRQ_TYPE, 32'h8);
      bus_write(OFF_IRQ_POL, 32'h0);
      bus_write(OFF_DEB_LIMIT, 32'h4);
      bus_write(OFF_IRQ_EN, 32'h8);
      exp_q.push_back(32'h4); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_q.push_back(32'h8); exp_q.push_back(32'h8);
      bus_read(OFF_DEB_LIMIT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL deb_limit_rw actual=%08h required=%08h", rd, ex); end
      @(negedge clk) gpio_in = 32'h8;
      repeat (3) @(negedge clk);
      gpio_in = 32'h0;
      repeat (10) @(posedge clk);
      bus_read(OFF_READ, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL deb_glitch_read actual=%08h required=%08h", rd, ex); end
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL deb_glitch_stat actual=%08h required=%08h", rd, ex); end
      @(negedge clk) gpio_in = 32'h8;
      repeat (12) @(posedge clk);
      bus_read(OFF_READ, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL deb_stable_read actual=%08h required=%08h", rd, ex); end
      bus_read(OFF_IRQ_STAT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL deb_stable_stat actual=%08h required=%08h", rd, ex); end
`else
      bus_write(OFF_DEB_LIMIT, 32'h1234);
      exp_q.push_back(32'h0);
      bus_read(OFF_DEB_LIMIT, rd); ex = exp_q.pop_front(); n_run++;
      if (rd !== ex) begin n_fail++; $display("FAIL deb_limit_absent actual=%08h required=%08h", rd, ex); end
`endif
   endtask

   initial begin
      rst              = 1'b1;
      gpio_in          = 32'h0;
      bus_if.bus_valid = 1'b0;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = 32'h0;
      bus_if.bus_wdata = 32'h0;
      test_reset();
      test_set_clr_tgl();
      test_edge_irq();
      test_level_low();
      test_set_wins();
      test_reset_mid();
      test_debounce();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_irq_ctrl_ip.md
# gpio_irq_ctrl_ip

Parametrised GPIO controller with per-pin interrupts. It sits on the same simple valid/we memory bus as the existing GPIO peripheral and exposes up to 32 bidirectional pins. Over a plain data/direction GPIO it adds:
- input synchronisation and optional debounce
- atomic set/clear/toggle writes
- per-pin edge- or level-triggered interrupts with sticky write-1-to-clear status
- a single combined interrupt output

## Interface
Parameters:
- WIDTH, 32, number of pins (1..32); register bits at and above WIDTH read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- DEB_CNT_W, 16, debounce counter width (used only with GPIO_IRQ_DEBOUNCE_EN)

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  asynchronous, active-high reset
- bus_valid  input  1  bus access strobe; a write occurs only when bus_valid=1 and bus_we=1
- bus_we  input  1  1 = write, 0 = read
- bus_addr  input  32  byte address; only bus_addr[7:0] is decoded
- bus_wdata  input  32  write data
- bus_rdata  output  32  combinational read data; 0 for unmapped offsets
- gpio_in  input  WIDTH  asynchronous pin inputs
- gpio_out  output  WIDTH  DATA & DIR
- gpio_oe  output  WIDTH  DIR (pad output enable)
- irq  output  1  registered; equals |(STAT & EN)

## Operation
Register map (offset: name, access):
- 0x00 DATA, RW
- 0x04 DIR, RW; 1 = output
- 0x08 READ, RO; (DIR & DATA) | (~DIR & pin_f), where pin_f is the filtered input
- 0x0C SET, WO; DATA |= wdata; reads 0
- 0x10 CLR, WO; DATA &= ~wdata; reads 0
- 0x14 TGL, WO; DATA ^= wdata; reads 0
- 0x18 IRQ_EN, RW
- 0x1C IRQ_TYPE, RW; 0 = level, 1 = edge
- 0x20 IRQ_POL, RW
  - level: 0 = high, 1 = low
  - edge: 0 = rising, 1 = falling
- 0x24 IRQ_STAT, R/W1C
- 0x28 DEB_LIMIT, RW; present only with the macro

Input path, per bit:
- gpio_in passes through SYNC_STAGES flops, giving pin_s.
- The debounce filter then gives pin_f.
- pin_p holds pin_f delayed by one cycle and updates every cycle.

Event for bit i, evaluated each cycle:
- Gated by EN[i] & ~DIR[i].
- Edge, rising: pin_f & ~pin_p.
- Edge, falling: ~pin_f & pin_p.
- Level: pin_f == ~POL[i].

STAT:
- An event sets STAT[i].
- A W1C write clears the written 1 bits.
- If a set and a clear hit the same bit in the same cycle, the set wins. A level source therefore cannot be cleared while it is active.
- Clearing EN[i] does not clear STAT[i]; it only masks irq.

Writes:
- Only the addressed register changes.
- Writes to READ or unmapped offsets have no effect.

## Timing
- Reset value of every register, synchroniser flop, pin_p, debounce counter, irq, gpio_out and gpio_oe is 0. bus_rdata follows the decode.
- Write latency: the register updates on the clk edge where bus_valid & bus_we. gpio_out/gpio_oe reflect the new value in the same cycle after that edge.
- Input latency, without debounce:
  - A pin change that is stable before edge 0 appears in READ after edge SYNC_STAGES-1.
  - STAT sets at edge SYNC_STAGES.
  - irq asserts at edge SYNC_STAGES+1.
- Only EN-gated events latch, so no spurious edge is recorded at reset release.
- Changing TYPE/POL/EN does not clear STAT. Re-enabling a bit while its pin is already high does not by itself create a rising edge.
- Reset asserted mid-operation clears everything immediately (asynchronously). Behaviour after release is identical to power-up.

## Configuration
- GPIO_IRQ_DEBOUNCE_EN defined:
  - Per bit, a DEB_CNT_W counter resets to 0 whenever pin_s == pin_f.
  - Otherwise the counter increments.
  - When it reaches DEB_LIMIT, pin_f takes pin_s and the counter returns to 0. A change must therefore persist DEB_LIMIT+1 cycles.
  - DEB_LIMIT=0 means pin_f follows pin_s with one cycle of added latency.
  - DEB_LIMIT resets to 0.
- GPIO_IRQ_DEBOUNCE_EN undefined: pin_f = pin_s, no counters, and 0x28 reads 0 with writes ignored.

## Structure
- Shared package gpio_irq_pkg: register offset localparams (DATA..DEB_LIMIT) and the TYPE/POL encodings.
- Sub-module gpio_in_filter:
  - Contains the WIDTH-wide synchroniser plus the optional debounce.
  - Outputs pin_f.
  - Carries the macro-guarded logic.
- Top level holds the bus decode, registers, edge/level detect, STAT and irq.

## Test plan
- Reset, then read all offsets -> all 0; irq=0, gpio_out=0. Write DIR=0xFF, DATA=0xA5 -> gpio_out=0x000000A5, READ[7:0]=0xA5.
- DATA=0xF0, then SET 0x0F -> 0xFF; CLR 0x81 -> 0x7E; TGL 0xFF -> 0x81. SET/CLR/TGL read back 0.
- EN[3]=1, TYPE[3]=1, POL[3]=0, pin3 rises at edge 0 -> STAT=0x8 at edge SYNC_STAGES, irq=1 one cycle later. W1C 0x8 -> irq=0. The falling edge is not latched.
- Level-low on bit 5 with pin held low -> STAT[5]=1; W1C while still low -> STAT[5] stays 1. Release pin, then W1C -> STAT=0.
- Edge event in the same cycle as W1C of the same bit -> STAT bit stays 1. Assert rst mid-sequence -> all registers 0 immediately.
- With GPIO_IRQ_DEBOUNCE_EN and DEB_LIMIT=4: a 3-cycle glitch -> no READ change and no STAT. A 5-cycle stable change -> READ updates and the edge is latched.
